// File: rtl/wasm_code_loader_if.sv
// -----------------------------------------------------------------------------
// wasm_code_loader_if
// Groups the byte-stream input and the instruction-memory write port of the
// WebAssembly code loader.
//   i_s_data / i_s_vld / i_s_last / o_s_rdy  : incoming binary, one byte per beat
//   o_wr_vld / i_wr_rdy                      : write word handshake (memory we)
//   o_wr_data                                : packed bytes, first byte in [7:0]
//   o_wr_shift_minusone                      : valid byte count minus one
// Modports: slave = the loader, master = the stream source / memory side.
// -----------------------------------------------------------------------------
interface wasm_code_loader_if #(
   parameter int WR_BYTES = 4,
   parameter int LOG_WR   = 2
);
   logic [7:0]              i_s_data;
   logic                    i_s_vld;
   logic                    i_s_last;
   logic                    o_s_rdy;
   logic                    o_wr_vld;
   logic                    i_wr_rdy;
   logic [8*WR_BYTES-1:0]   o_wr_data;
   logic [LOG_WR-1:0]       o_wr_shift_minusone;

   modport slave (
      input  i_s_data, i_s_vld, i_s_last, i_wr_rdy,
      output o_s_rdy, o_wr_vld, o_wr_data, o_wr_shift_minusone
   );

   modport master (
      output i_s_data, i_s_vld, i_s_last, i_wr_rdy,
      input  o_s_rdy, o_wr_vld, o_wr_data, o_wr_shift_minusone
   );
endinterface

// File: rtl/wasm_code_loader.sv
// -----------------------------------------------------------------------------
// wasm_code_loader
// Boot-time loader: checks the WebAssembly header, walks the section list,
// skips every section except the code section (id 0x0A) and packs its payload
// into WR_BYTES-wide words for the instruction memory. The core is held until
// the code section has been written completely.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   bus              stream input + memory write port (slave modport)
//   o_code_len       decoded code-section length
//   o_core_hold      high until the load is done
//   o_load_done      sticky success flag
//   o_format_error   sticky error flag
//   o_err_code       1 header, 2 LEB128 overflow, 3 code too large, 4 truncated
// -----------------------------------------------------------------------------
module wasm_code_loader #(
   parameter int WR_BYTES       = 4,
   parameter int LOG_WR         = 2,
   parameter int MAX_CODE_BYTES = 1024
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   wasm_code_loader_if.slave  bus,
   output logic [31:0]        o_code_len,
   output logic               o_core_hold,
   output logic               o_load_done,
   output logic               o_format_error,
   output logic [2:0]         o_err_code
);
   localparam int CW = $clog2(WR_BYTES + 1);
   // "\0asm" magic followed by version 1, first byte in [7:0]
   localparam logic [63:0] WASM_HDR = 64'h0000_0001_6D73_6100;

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_HDR   = 3'd1;
   localparam logic [2:0] ERR_LEB   = 3'd2;
   localparam logic [2:0] ERR_BIG   = 3'd3;
   localparam logic [2:0] ERR_TRUNC = 3'd4;

   typedef enum logic [2:0] {
      S_HDR, S_SEC_ID, S_SEC_LEN, S_SKIP, S_CODE, S_DONE, S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [2:0]            err_d, err_code_q;
   logic [2:0]            hdr_cnt_q;
   logic [7:0]            sec_id_q;
   logic [31:0]           len_acc_q, skip_cnt_q, code_rem_q;
   logic [2:0]            leb_k_q;
   logic [8*WR_BYTES-1:0] pack_buf_q, word_next;
   logic [CW-1:0]         pack_cnt_q, cnt_after;
   logic                  wr_vld_q;
   logic [8*WR_BYTES-1:0] wr_data_q;
   logic [LOG_WR-1:0]     wr_shift_q;

   logic        byte_fire, word_fire;
   logic [7:0]  hdr_byte;
   logic [5:0]  leb_sh;
   logic [31:0] leb_val;
   logic        leb_term, leb_ovf, is_code, emit;

   assign byte_fire = bus.i_s_vld & bus.o_s_rdy;
   assign word_fire = wr_vld_q & bus.i_wr_rdy;
   assign hdr_byte  = WASM_HDR[{hdr_cnt_q, 3'b000} +: 8];
   assign is_code   = (sec_id_q == 8'h0A);

   // LEB128 step: the 5th byte may only contribute bits [31:28]
   assign leb_sh    = {3'b000, leb_k_q} * 6'd7;
   assign leb_val   = len_acc_q | ({25'd0, bus.i_s_data[6:0]} << leb_sh);
   assign leb_term  = ~bus.i_s_data[7];
   assign leb_ovf   = (leb_k_q == 3'd4) && (bus.i_s_data[7] || (bus.i_s_data[6:4] != 3'd0));

   // A word goes out when full or when the final code byte has been taken
   assign cnt_after = pack_cnt_q + CW'(1);
   assign emit      = (cnt_after == CW'(WR_BYTES)) || (code_rem_q == 32'd1);

   always_comb begin
      word_next = pack_buf_q;
      for (int i = 0; i < WR_BYTES; i++)
         if (pack_cnt_q == CW'(i)) word_next[8*i +: 8] = bus.i_s_data;
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= S_HDR;
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      else          state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned (no latch).
      state_d = state_q;
      err_d   = ERR_NONE;
      case (state_q)
         S_HDR: if (byte_fire) begin
            if (bus.i_s_data != hdr_byte) begin state_d = S_ERROR; err_d = ERR_HDR;   end
            else if (bus.i_s_last)        begin state_d = S_ERROR; err_d = ERR_TRUNC; end
            else if (hdr_cnt_q == 3'd7)         state_d = S_SEC_ID;
         end
         S_SEC_ID: if (byte_fire) begin
            if (bus.i_s_last) begin state_d = S_ERROR; err_d = ERR_TRUNC; end
            else                    state_d = S_SEC_LEN;
         end
         S_SEC_LEN: if (byte_fire) begin
            if (leb_ovf) begin
               state_d = S_ERROR; err_d = ERR_LEB;
            end else if (leb_term && is_code && (leb_val > 32'(MAX_CODE_BYTES))) begin
               state_d = S_ERROR; err_d = ERR_BIG;
            end else if (bus.i_s_last) begin
               state_d = S_ERROR; err_d = ERR_TRUNC;
            end else if (leb_term) begin
               if (is_code) state_d = (leb_val == 32'd0) ? S_DONE   : S_CODE;
               else         state_d = (leb_val == 32'd0) ? S_SEC_ID : S_SKIP;
            end
         end
         S_SKIP: if (byte_fire) begin
            if (bus.i_s_last)                 begin state_d = S_ERROR; err_d = ERR_TRUNC; end
            else if (skip_cnt_q == 32'd1)           state_d = S_SEC_ID;
         end
         S_CODE: begin
            // All code bytes taken: finish once the final word is accepted
            if (code_rem_q == 32'd0) begin
               if (word_fire) state_d = S_DONE;
            end else if (byte_fire && bus.i_s_last && (code_rem_q != 32'd1)) begin
               state_d = S_ERROR; err_d = ERR_TRUNC;
            end
         end
         default: ;
      endcase
   end

   // Outputs decoded from state; input stalls only behind a refused word
   always_comb begin
      bus.o_s_rdy    = ~(wr_vld_q & ~bus.i_wr_rdy);
      o_core_hold    = (state_q != S_DONE);
      o_load_done    = (state_q == S_DONE);
      o_format_error = (state_q == S_ERROR);
   end

   assign bus.o_wr_vld            = wr_vld_q;
   assign bus.o_wr_data           = wr_data_q;
   assign bus.o_wr_shift_minusone = wr_shift_q;
   assign o_err_code              = err_code_q;

   // Datapath: counters, LEB128 accumulator, pack buffer, write word
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_code_q <= ERR_NONE;
         hdr_cnt_q  <= '0;
         sec_id_q   <= '0;
         len_acc_q  <= '0;
         leb_k_q    <= '0;
         skip_cnt_q <= '0;
         code_rem_q <= '0;
         pack_buf_q <= '0;
         pack_cnt_q <= '0;
         wr_vld_q   <= 1'b0;
         wr_data_q  <= '0;
         wr_shift_q <= '0;
         o_code_len <= '0;
      end else begin
         // A new word emitted below in the same cycle overrides this clear
         if (word_fire) wr_vld_q <= 1'b0;
         if ((state_d == S_ERROR) && (state_q != S_ERROR)) err_code_q <= err_d;
         if (byte_fire) begin
            case (state_q)
               S_HDR:    hdr_cnt_q <= hdr_cnt_q + 3'd1;
               S_SEC_ID: begin
                  sec_id_q  <= bus.i_s_data;
                  len_acc_q <= '0;
                  leb_k_q   <= '0;
               end
               S_SEC_LEN: begin
                  len_acc_q <= leb_val;
                  leb_k_q   <= leb_k_q + 3'd1;
                  if (leb_term) begin
                     skip_cnt_q <= leb_val;
                     code_rem_q <= leb_val;
                  end
                  if (state_d == S_CODE) o_code_len <= leb_val;
               end
               S_SKIP: skip_cnt_q <= skip_cnt_q - 32'd1;
               S_CODE: if ((code_rem_q != 32'd0) && (state_d == S_CODE)) begin
                  code_rem_q <= code_rem_q - 32'd1;
                  if (emit) begin
                     wr_vld_q   <= 1'b1;
                     wr_data_q  <= word_next;
                     wr_shift_q <= LOG_WR'(cnt_after - CW'(1));
                     pack_buf_q <= '0;
                     pack_cnt_q <= '0;
                  end else begin
                     pack_buf_q <= word_next;
                     pack_cnt_q <= cnt_after;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_wasm_code_loader.sv
// -----------------------------------------------------------------------------
// tb_wasm_code_loader
// Directed bench for wasm_code_loader: valid loads with and without skipped
// sections, each error cause, write back-pressure and reset mid-load.
// Inputs change 1 time unit after the rising edge; status is read there too,
// written words are logged on the falling edge when o_wr_vld & i_wr_rdy.
// -----------------------------------------------------------------------------
module tb_wasm_code_loader;
   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] code_len;
   logic        core_hold, load_done, format_error;
   logic [2:0]  err_code;

   int checks   = 0;
   int failures = 0;

   logic [31:0] wq_data  [$];
   logic [1:0]  wq_shift [$];
   logic [7:0]  hdr_bytes [8];
   logic [7:0]  pay [$];

   wasm_code_loader_if #(.WR_BYTES(4), .LOG_WR(2)) bus ();

   wasm_code_loader #(.WR_BYTES(4), .LOG_WR(2), .MAX_CODE_BYTES(1024)) dut (
      .i_clk          (clk),
      .i_rst_n        (rst_n),
      .bus            (bus),
      .o_code_len     (code_len),
      .o_core_hold    (core_hold),
      .o_load_done    (load_done),
      .o_format_error (format_error),
      .o_err_code     (err_code)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rst_n && bus.o_wr_vld && bus.i_wr_rdy) begin
         wq_data.push_back(bus.o_wr_data);
         wq_shift.push_back(bus.o_wr_shift_minusone);
      end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Called at posedge+1; returns at posedge+1 after the byte has transferred
   task automatic send_byte(input logic [7:0] b, input logic last);
      int n = 0;
      bus.i_s_data = b;
      bus.i_s_vld  = 1'b1;
      bus.i_s_last = last;
      @(negedge clk);
      while (!bus.o_s_rdy && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("byte_accepted", 32'(bus.o_s_rdy), 32'd1);
      @(posedge clk); #1;
      bus.i_s_vld  = 1'b0;
      bus.i_s_last = 1'b0;
   endtask

   task automatic send_q(input logic [7:0] q [$], input logic last_on_final);
      foreach (q[i]) send_byte(q[i], last_on_final && (i == q.size() - 1));
   endtask

   task automatic send_header();
      for (int i = 0; i < 8; i++) send_byte(hdr_bytes[i], 1'b0);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.i_s_data = 8'h00;
      bus.i_s_vld  = 1'b0;
      bus.i_s_last = 1'b0;
      bus.i_wr_rdy = 1'b1;
      rst_n        = 1'b0;
      wait_cycles(2);
      wq_data.delete();
      wq_shift.delete();
      rst_n = 1'b1;
      wait_cycles(1);
   endtask

   task automatic check_word(input string tag, input logic [31:0] d, input logic [1:0] s);
      chk({tag, "_present"}, 32'(wq_data.size() > 0), 32'd1);
      if (wq_data.size() > 0) begin
         chk({tag, "_data"},  wq_data.pop_front(), d);
         chk({tag, "_shift"}, 32'(wq_shift.pop_front()), 32'(s));
      end
   endtask

   task automatic check_status(input string tag, input logic done, input logic hold,
                               input logic ferr, input logic [2:0] ecode);
      chk({tag, "_load_done"},    32'(load_done),    32'(done));
      chk({tag, "_core_hold"},    32'(core_hold),    32'(hold));
      chk({tag, "_format_error"}, 32'(format_error), 32'(ferr));
      chk({tag, "_err_code"},     32'(err_code),     32'(ecode));
   endtask

   initial begin
      hdr_bytes    = '{8'h00, 8'h61, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
      bus.i_s_data = 8'h00;
      bus.i_s_vld  = 1'b0;
      bus.i_s_last = 1'b0;
      bus.i_wr_rdy = 1'b1;
      rst_n        = 1'b0;
      wait_cycles(2);

      // Reset values
      chk("rst_wr_vld",   32'(bus.o_wr_vld), 32'd0);
      chk("rst_wr_data",  bus.o_wr_data, 32'd0);
      chk("rst_wr_shift", 32'(bus.o_wr_shift_minusone), 32'd0);
      chk("rst_code_len", code_len, 32'd0);
      chk("rst_s_rdy",    32'(bus.o_s_rdy), 32'd1);
      check_status("rst", 1'b0, 1'b1, 1'b0, 3'd0);
      rst_n = 1'b1;
      wait_cycles(1);

      // Code section only, 6 bytes -> full word + 2-byte tail
      send_header();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h06, 1'b0);
      pay = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h0B};
      send_q(pay, 1'b1);
      wait_cycles(4);
      check_word("a_w1", 32'h0341_0541, 2'd3);
      check_word("a_w2", 32'h0000_0B6A, 2'd1);
      chk("a_no_extra", 32'(wq_data.size()), 32'd0);
      chk("a_code_len", code_len, 32'd6);
      check_status("a", 1'b1, 1'b0, 1'b0, 3'd0);

      // Type section skipped, then 3-byte code section
      do_reset();
      send_header();
      pay = '{8'h01, 8'h05, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      send_q(pay, 1'b0);
      wait_cycles(1);
      chk("b_skip_no_writes", 32'(wq_data.size()), 32'd0);
      chk("b_skip_wr_vld",    32'(bus.o_wr_vld), 32'd0);
      send_byte(8'h0A, 1'b0);
      send_byte(8'h03, 1'b0);
      pay = '{8'h01, 8'h02, 8'h03};
      send_q(pay, 1'b1);
      wait_cycles(4);
      check_word("b_w1", 32'h0003_0201, 2'd2);
      chk("b_no_extra", 32'(wq_data.size()), 32'd0);
      chk("b_code_len", code_len, 32'd3);
      check_status("b", 1'b1, 1'b0, 1'b0, 3'd0);

      // Bad magic byte 2
      do_reset();
      pay = '{8'h00, 8'h62, 8'h73, 8'h6D, 8'h01, 8'h00, 8'h00, 8'h00};
      send_q(pay, 1'b0);
      wait_cycles(2);
      chk("hdr_no_writes", 32'(wq_data.size()), 32'd0);
      check_status("hdr", 1'b0, 1'b1, 1'b1, 3'd1);

      // LEB128 overflow on the 5th length byte
      do_reset();
      send_header();
      send_byte(8'h0A, 1'b0);
      pay = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h10};
      send_q(pay, 1'b0);
      wait_cycles(2);
      check_status("leb", 1'b0, 1'b1, 1'b1, 3'd2);

      // Code length 1025 exceeds capacity
      do_reset();
      send_header();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h81, 1'b0);
      send_byte(8'h08, 1'b0);
      wait_cycles(2);
      chk("big_code_len", code_len, 32'd0);
      check_status("big", 1'b0, 1'b1, 1'b1, 3'd3);

      // Back-pressure: first word refused for 5 cycles
      do_reset();
      send_header();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h08, 1'b0);
      bus.i_wr_rdy = 1'b0;
      pay = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_q(pay, 1'b0);
      bus.i_s_data = 8'h55;
      bus.i_s_vld  = 1'b1;
      bus.i_s_last = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("stall_s_rdy",   32'(bus.o_s_rdy), 32'd0);
         chk("stall_wr_vld",  32'(bus.o_wr_vld), 32'd1);
         chk("stall_wr_data", bus.o_wr_data, 32'h4433_2211);
         wait_cycles(1);
      end
      chk("stall_no_accept", 32'(wq_data.size()), 32'd0);
      bus.i_wr_rdy = 1'b1;
      send_byte(8'h55, 1'b0);
      send_byte(8'h66, 1'b0);
      send_byte(8'h77, 1'b0);
      send_byte(8'h88, 1'b1);
      wait_cycles(4);
      check_word("stall_w1", 32'h4433_2211, 2'd3);
      check_word("stall_w2", 32'h8877_6655, 2'd3);
      chk("stall_no_extra", 32'(wq_data.size()), 32'd0);
      chk("stall_code_len", code_len, 32'd8);
      check_status("stall", 1'b1, 1'b0, 1'b0, 3'd0);

      // Stream ends on the section length byte
      do_reset();
      send_header();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h02, 1'b1);
      wait_cycles(2);
      chk("trunc_no_writes", 32'(wq_data.size()), 32'd0);
      check_status("trunc", 1'b0, 1'b1, 1'b1, 3'd4);

      // Reset while a code word is pending, then a clean reload
      do_reset();
      send_header();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h06, 1'b0);
      pay = '{8'h41, 8'h05, 8'h41, 8'h03};
      send_q(pay, 1'b0);
      chk("mid_pre_wr_vld", 32'(bus.o_wr_vld), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_wr_vld",   32'(bus.o_wr_vld), 32'd0);
      chk("mid_wr_data",  bus.o_wr_data, 32'd0);
      chk("mid_wr_shift", 32'(bus.o_wr_shift_minusone), 32'd0);
      chk("mid_code_len", code_len, 32'd0);
      check_status("mid", 1'b0, 1'b1, 1'b0, 3'd0);
      do_reset();
      send_header();
      send_byte(8'h0A, 1'b0);
      send_byte(8'h06, 1'b0);
      pay = '{8'h41, 8'h05, 8'h41, 8'h03, 8'h6A, 8'h0B};
      send_q(pay, 1'b1);
      wait_cycles(4);
      check_word("reload_w1", 32'h0341_0541, 2'd3);
      check_word("reload_w2", 32'h0000_0B6A, 2'd1);
      chk("reload_code_len", code_len, 32'd6);
      check_status("reload", 1'b1, 1'b0, 1'b0, 3'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/wasm_code_loader.md
Name: wasm_code_loader

Overview:
- Boot-time instruction loader that sits directly upstream of the instruction memory controller.
- Consumes a raw WebAssembly binary as a byte stream, checks the module header, walks the section list, and skips every section except the code section (id 0x0A).
- Packs the code-section payload into multi-byte write words for the instruction memory write port (write enable, write_pointer_shift_minusone, wr_data).
- Holds the core in hold until the load completes.

Parameters:
- WR_BYTES, 4, bytes per instruction-memory write word.
- LOG_WR, 2, width of o_wr_shift_minusone; equals log2(WR_BYTES).
- MAX_CODE_BYTES, 1024, instruction memory capacity in bytes; a larger code section is an error.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_s_data  in  8  stream byte.
- i_s_vld  in  1  byte valid.
- i_s_last  in  1  final byte of the binary; qualified by i_s_vld.
- o_s_rdy  out  1  loader accepts the byte.
- o_wr_vld  out  1  write word valid (drives instruction memory we).
- i_wr_rdy  in  1  memory accepts the word.
- o_wr_data  out  8*WR_BYTES  packed bytes; first byte in [7:0].
- o_wr_shift_minusone  out  LOG_WR  valid byte count minus 1.
- o_code_len  out  32  decoded code-section length.
- o_core_hold  out  1  high until DONE.
- o_load_done  out  1  sticky: load successful.
- o_format_error  out  1  sticky: error.
- o_err_code  out  3  cause: 1 magic/version, 2 LEB128 overflow, 3 code too large, 4 truncated/no code section.

Behaviour:
- Reset (asynchronous, any state): state=HDR; all counters and pack buffer cleared; o_wr_vld=0, o_wr_data=0, o_wr_shift_minusone=0, o_code_len=0, o_core_hold=1, o_load_done=0, o_format_error=0, o_err_code=0. Reset mid-load discards partial words.
- Handshake: a byte transfers when i_s_vld & o_s_rdy. A word transfers when o_wr_vld & i_wr_rdy.
- o_s_rdy = ~(o_wr_vld & ~i_wr_rdy). Input stalls only while a write word is pending and refused.
- o_wr_vld/data/shift are held stable until accepted.
- HDR: compare 8 bytes against 00 61 73 6D 01 00 00 00. First mismatch -> ERROR(1). After byte 8 -> SEC_ID.
- SEC_ID: latch id -> SEC_LEN.
- SEC_LEN: unsigned LEB128 decode, value |= (b&0x7F)<<(7*k).
  - 5th byte with continuation bit set, or 5th byte with any of bits[6:4] nonzero -> ERROR(2).
  - On the terminating byte:
    - id==0x0A and len>MAX_CODE_BYTES -> ERROR(3).
    - id==0x0A and len==0 -> DONE (no writes).
    - id==0x0A otherwise -> CODE, with o_code_len=len.
    - other id, len==0 -> SEC_ID.
    - other id -> SKIP.
- SKIP: down-count len bytes, discarding them; at zero -> SEC_ID.
- CODE: append each byte to the pack buffer at index cnt.
  - Emit a word (o_wr_vld=1 next cycle, shift_minusone=cnt_after-1) when cnt reaches WR_BYTES or when the last code byte is taken.
  - Unused upper bytes of a partial word are 0.
  - The buffer refills in the same cycle the previous word is still pending only if o_s_rdy allows.
  - After the last code byte's word is accepted -> DONE.
- DONE: o_load_done=1, o_core_hold=0. Remaining stream bytes are accepted and discarded (o_s_rdy=1).
- ERROR: o_format_error=1, o_core_hold stays 1, bytes are accepted and discarded. Exit is by reset only.
- i_s_last accepted in HDR, SEC_ID, SEC_LEN, SKIP, or CODE before the last code byte -> ERROR(4). Any word already pending still completes.
- Simultaneous: a last code byte arriving with i_s_last is legal and leads to DONE.
- Word accept and new byte in the same cycle are both honoured.
- Widths: all length counters are 32 bits. MAX_CODE_BYTES compare is unsigned.

Test Plan:
- Header 00 61 73 6D 01 00 00 00, section 0A 06, payload 41 05 41 03 6A 0B, i_wr_rdy=1 -> word 1: data 0x0341_0541, shift 3; word 2: data 0x0000_0B6A, shift 1; then o_load_done=1, o_core_hold=0, o_code_len=6.
- Type section 01 05 + 5 bytes, then code section 0A 03 01 02 03 -> the first 7 bytes after the header produce no writes; single word 0x00030201, shift 2; done.
- Byte 2 of the header = 0x62 -> o_format_error=1, o_err_code=1, no writes, o_core_hold=1.
- Code length encoded 80 80 80 80 10 -> ERROR(2). Length 81 08 (=1025) with MAX_CODE_BYTES=1024 -> ERROR(3).
- i_wr_rdy=0 for 5 cycles while a word is pending -> o_s_rdy=0, o_wr_data stable, no byte lost; the full 8-byte payload arrives intact across 2 words.
- i_s_last on SEC_LEN byte 0x0A 02 (before payload) -> ERROR(4). Assert i_rst_n low mid-CODE -> all outputs return to reset values immediately; a reload then succeeds.
